// File: rtl/mips_defs.sv
// Shared MIPS definitions: multiply/divide op codes used by the decoder and md_unit,
// plus the md_unit sequencing states.
package mips_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_unit_core.sv
// Combinational arithmetic for md_unit: 64-bit product and quotient/remainder,
// signed or unsigned according to the op, with a divide-by-zero flag.
module md_core
    import mips_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign signed_op = (op == MD_MULT) || (op == MD_DIV);

    // Sign-extending to 64 bits makes the truncated 64-bit product correct for both signednesses.
    assign a_ext   = {{32{signed_op & a[31]}}, a};
    assign b_ext   = {{32{signed_op & b[31]}}, b};
    assign product = a_ext * b_ext;

    // Divide on magnitudes so -2^31 / -1 wraps cleanly instead of overflowing a signed divider.
    assign a_neg    = signed_op & a[31];
    assign b_neg    = signed_op & b[31];
    assign a_mag    = a_neg ? (~a + 32'd1) : a;
    assign b_mag    = b_neg ? (~b + 32'd1) : b;
    assign div_zero = (b == 32'd0);
    assign divisor  = div_zero ? 32'd1 : b_mag;
    assign q_mag    = a_mag / divisor;
    assign r_mag    = a_mag % divisor;

    assign quotient  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign remainder = a_neg ? (~r_mag + 32'd1) : r_mag;

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Results are computed at accept and held
// in pending registers until the busy counter expires, then committed to HI/LO.
module md_unit
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state;
    md_state_e        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [31:0]      phi;
    logic [31:0]      phi_n;
    logic [31:0]      plo;
    logic [31:0]      plo_n;
    logic             pcommit;
    logic             pcommit_n;
    logic [31:0]      hi_n;
    logic [31:0]      lo_n;
    logic             accept;
    md_op_e           op_e;

    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    md_core u_core (
        .op        (op),
        .a         (a),
        .b         (b),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    assign op_e   = md_op_e'(op);
    assign busy   = (state == MD_RUN);
    assign accept = start && !cancel && (state == MD_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            phi     <= '0;
            plo     <= '0;
            pcommit <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            phi     <= phi_n;
            plo     <= plo_n;
            pcommit <= pcommit_n;
            hi      <= hi_n;
            lo      <= lo_n;
        end
    end

    // A divide by zero still runs the full latency but leaves pcommit clear, so HI/LO are untouched.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        phi_n     = phi;
        plo_n     = plo;
        pcommit_n = pcommit;
        hi_n      = hi;
        lo_n      = lo;
        case (state)
            MD_IDLE: begin
                if (accept) begin
                    case (op_e)
                        MD_MULT, MD_MULTU: begin
                            phi_n     = product[63:32];
                            plo_n     = product[31:0];
                            pcommit_n = 1'b1;
                            cnt_n     = MULT_CNT;
                            state_n   = MD_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            phi_n     = remainder;
                            plo_n     = quotient;
                            pcommit_n = !div_zero;
                            cnt_n     = DIV_CNT;
                            state_n   = MD_RUN;
                        end
                        MD_MTHI: hi_n = a;
                        MD_MTLO: lo_n = a;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                if (cnt == CNT_ONE) begin
                    state_n = MD_IDLE;
                    cnt_n   = '0;
                    if (pcommit) begin
                        hi_n = phi;
                        lo_n = plo;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: state_n = MD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO and busy length,
// a monitor pops and compares each time busy falls.
module tb_md_unit;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   run_len = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: a busy run ending is the DUT presenting a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                run_len++;
            end else if (run_len > 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_completion: got busy run of %0d expected none", run_len);
                end else begin
                    e = sb.pop_front();
                    check_output("completion_hi", hi, e.hi);
                    check_output("completion_lo", lo, e.lo);
                    check_output("busy_cycles", 32'(run_len), 32'(e.cycles));
                end
                run_len = 0;
            end
        end
    end

    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] av,
                                  input logic [31:0] bv, input logic c);
        @(negedge clk);
        start  = 1'b1;
        cancel = c;
        op     = o;
        a      = av;
        b      = bv;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        op     = MD_NONE;
    endtask

    task automatic expect_result(input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.hi     = h;
        e.lo     = l;
        e.cycles = n;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got busy=%b expected 0", name, busy);
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_pending: got %0d outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = MD_NONE;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_hi", hi, 32'h0);
        check_output("reset_lo", lo, 32'h0);

        // Signed and unsigned multiplies.
        expect_result(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        apply_stimulus(MD_MULT, 32'd3, 32'hFFFFFFFE, 1'b0);
        wait_idle("mult");
        expect_result(32'h00000001, 32'hFFFFFFFE, 5);
        apply_stimulus(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_idle("multu");

        // Signed divides with negative dividend and negative divisor.
        expect_result(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        apply_stimulus(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle("div_neg_a");
        expect_result(32'h00000001, 32'hFFFFFFFD, 10);
        apply_stimulus(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
        wait_idle("div_neg_b");

        // Move-to HI/LO then a divide by zero that must leave them alone.
        apply_stimulus(MD_MTHI, 32'h11, 32'h0, 1'b0);
        check_output("mthi_hi", hi, 32'h11);
        check_output("mthi_busy", 32'(busy), 32'd0);
        apply_stimulus(MD_MTLO, 32'h22, 32'h0, 1'b0);
        check_output("mtlo_lo", lo, 32'h22);
        check_output("mtlo_hi", hi, 32'h11);
        expect_result(32'h11, 32'h22, 10);
        apply_stimulus(MD_DIVU, 32'd7, 32'd0, 1'b0);
        wait_idle("divu_zero");

        // A start while busy is ignored.
        expect_result(32'h0, 32'h2A, 5);
        apply_stimulus(MD_MULT, 32'd6, 32'd7, 1'b0);
        apply_stimulus(MD_DIV, 32'd100, 32'd3, 1'b0);
        wait_idle("start_while_busy");

        // A start on the edge busy falls is refused.
        expect_result(32'h0, 32'h6, 5);
        apply_stimulus(MD_MULTU, 32'd2, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        apply_stimulus(MD_MTHI, 32'h55, 32'h0, 1'b0);
        wait_idle("start_on_fall");
        check_output("start_on_fall_hi", hi, 32'h0);

        // Cancel while busy has no effect on the running op.
        expect_result(32'h1, 32'h0, 5);
        apply_stimulus(MD_MULTU, 32'h00010000, 32'h00010000, 1'b0);
        apply_stimulus(MD_NONE, 32'h0, 32'h0, 1'b1);
        wait_idle("cancel_busy");

        // Start together with cancel is dropped; MD_NONE does nothing.
        apply_stimulus(MD_MULT, 32'd9, 32'd9, 1'b1);
        check_output("cancel_start_busy", 32'(busy), 32'd0);
        apply_stimulus(MD_MTLO, 32'h77, 32'h0, 1'b1);
        check_output("cancel_mtlo_lo", lo, 32'h0);
        apply_stimulus(MD_NONE, 32'h99, 32'h99, 1'b0);
        check_output("none_busy", 32'(busy), 32'd0);
        check_output("none_hi", hi, 32'h1);
        check_output("none_lo", lo, 32'h0);

        // Reset in the third busy cycle aborts the op.
        expect_result(32'h0, 32'h0, 3);
        apply_stimulus(MD_MULT, 32'd5, 32'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_hi", hi, 32'h0);
        check_output("abort_lo", lo, 32'h0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL abort_pending: got %0d outstanding expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
